// File: rtl/des_sched.sv
// Generic first-word-fall-through FIFO with synchronous clear.
// Latency: a write is visible at the head the cycle after the push edge.
// Backpressure: writes are ignored when full unless a pop happens on the same edge.
module des_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rp];
    assign count  = cnt;
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && ((cnt != FULL) || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_dat;
                wp      <= wp + AW'(1);
            end
            if (do_rd) rp <= rp + AW'(1);
            cnt <= cnt + {{(CW-1){1'b0}}, do_wr} - {{(CW-1){1'b0}}, do_rd};
        end
    end
endmodule

// Issues encrypt requests into des_enc, tracks tags and buffers ciphertexts in order.
// Latency: accept at E0 -> capture at E0+LATENCY -> res_valid in the following cycle.
// Backpressure: credit-based; req_ready drops once in-flight plus queued blocks reach DEPTH.
module des_sched #(
    parameter int LATENCY = 16,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_pt,
    input  logic [TAGW-1:0]          req_tag,
    output logic [63:0]              des_in,
    input  logic [63:0]              des_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [63:0]              res_ct,
    output logic [TAGW-1:0]          res_tag,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   inflight
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [LATENCY-1:0] sr_vld;
    logic [TAGW-1:0]    sr_tag [LATENCY];
    logic [CW-1:0]      fifo_cnt;
    logic [CW:0]        used;
    logic               accept;
    logic               capture;
    logic [63+TAGW:0]   head;

    // Credit check sees only registered counts, never req_valid or res_ready.
    assign used      = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign req_ready = !flush && (used < CREDITS);
    assign accept    = req_valid && req_ready;
    assign capture   = sr_vld[LATENCY-1] && !flush;
    assign busy      = (inflight != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            des_in <= '0;
        end else if (accept) begin
            des_in <= req_pt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_vld <= '0;
            for (int i = 0; i < LATENCY; i++) sr_tag[i] <= '0;
        end else begin
            sr_vld[0] <= accept;
            sr_tag[0] <= accept ? req_tag : '0;
            for (int i = 1; i < LATENCY; i++) begin
                sr_vld[i] <= flush ? 1'b0 : sr_vld[i-1];
                sr_tag[i] <= sr_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else if (accept && !capture) begin
            inflight <= inflight + CW'(1);
        end else if (!accept && capture) begin
            inflight <= inflight - CW'(1);
        end
    end

    des_fifo #(
        .W     (64 + TAGW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .wr_vld (capture),
        .wr_dat ({des_out, sr_tag[LATENCY-1]}),
        .rd_vld (res_valid),
        .rd_rdy (res_ready),
        .rd_dat (head),
        .count  (fifo_cnt)
    );

    assign {res_ct, res_tag} = head;
endmodule

// File: tb/tb_des_sched.sv
// Directed bench for des_sched with a behavioural des_enc pipeline and an in-order scoreboard.
module tb_des_sched;
    localparam int LATENCY = 16;
    localparam int DEPTH   = 4;
    localparam int TAGW    = 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [63:0]     ct;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [63:0]     req_pt;
    logic [TAGW-1:0] req_tag;
    logic [63:0]     des_in;
    logic [63:0]     des_out;
    logic            res_valid;
    logic            res_ready;
    logic [63:0]     res_ct;
    logic [TAGW-1:0] res_tag;
    logic            busy;
    logic [CW-1:0]   inflight;

    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    exp_t sb[$];
    logic [63:0] core_pipe [LATENCY-1];

    des_sched #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pt    (req_pt),
        .req_tag   (req_tag),
        .des_in    (des_in),
        .des_out   (des_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ct    (res_ct),
        .res_tag   (res_tag),
        .busy      (busy),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] enc(input logic [63:0] x);
        return {x[31:0], x[63:32]} ^ 64'hDEADBEEF0F1E2D3C;
    endfunction

    // Stand-in for des_enc: the result for des_in launched at E0 is presented for the capture at E0+LATENCY.
    always @(posedge clk) begin
        core_pipe[0] <= des_in;
        for (int i = 1; i < LATENCY - 1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign des_out = enc(core_pipe[LATENCY-2]);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (res_valid && res_ready) begin
                e = 'x;
                if (sb.size() != 0) e = sb.pop_front();
                chk("res_ct", res_ct, e.ct);
                chk("res_tag", 64'(res_tag), 64'(e.tag));
            end
            if (req_valid && req_ready) begin
                sb.push_back({enc(req_pt), req_tag});
                acc_cnt++;
            end
            if (flush) sb.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({pfx, "_des_in"},    des_in,          64'd0);
        chk({pfx, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({pfx, "_res_ct"},    res_ct,          64'd0);
        chk({pfx, "_res_tag"},   64'(res_tag),   64'd0);
        chk({pfx, "_busy"},      64'(busy),      64'd0);
        chk({pfx, "_inflight"},  64'(inflight),  64'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        req_valid = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while (n < 80 && (sb.size() != 0 || res_valid || busy)) begin
            tick();
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
        chk({tag, "_idle"}, 64'(res_valid | busy), 64'd0);
    endtask

    initial begin
        int bc, first, last, cnt, pops, stray;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pt = '0; req_tag = '0; res_ready = 1'b0;
        #3;
        check_reset_vals("rst");
        #9 rst = 1'b0;
        tick();

        // Single request and its latency/busy window
        res_ready = 1'b1;
        req_valid = 1'b1; req_pt = 64'h0123456789ABCDEF; req_tag = 8'h5A;
        chk("single_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("single_des_in", des_in, 64'h0123456789ABCDEF);
        bc = 0; first = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (res_valid && first < 0) first = k;
        end
        chk("single_latency", 64'(first), 64'd16);
        chk("single_busy_cycles", 64'(bc), 64'd16);
        tick();

        // Back-to-back burst, results on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_pt = {$urandom, $urandom}; req_tag = TAGW'(i);
            tick();
        end
        req_valid = 1'b0;
        cnt = 0; first = -1; last = -1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (res_valid) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("burst_count", 64'(cnt), 64'd4);
        chk("burst_span", 64'(last - first), 64'd3);
        tick();

        // Backpressure: credits cap accepts at DEPTH
        res_ready = 1'b0; acc_cnt = 0; req_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            req_pt = {$urandom, $urandom}; req_tag = TAGW'(8'h40 + i);
            tick();
        end
        chk("bp_accepts", 64'(acc_cnt), 64'd4);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_ready_back", 64'(req_ready), 64'd1);
        tick();
        chk("bp_ready_again_low", 64'(req_ready), 64'd0);
        chk("bp_accepts_after_pop", 64'(acc_cnt), 64'd5);
        drain("bp_drain");

        // Simultaneous push/pop with two entries queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_pt = {$urandom, $urandom}; req_tag = TAGW'(8'h60 + i);
            tick();
        end
        req_valid = 1'b0;
        repeat (14) tick();
        chk("pp_queued", 64'(res_valid), 64'd1);
        chk("pp_inflight", 64'(inflight), 64'd2);
        res_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (res_valid) pops++;
            tick();
        end
        chk("pp_pops", 64'(pops), 64'd4);
        chk("pp_empty", 64'(res_valid), 64'd0);

        // Pointer wrap: 12 blocks with random consumer stalls
        acc_cnt = 0;
        for (int c = 0; c < 600 && acc_cnt < 12; c++) begin
            req_valid = 1'b1; req_pt = {$urandom, $urandom}; req_tag = TAGW'(8'h80 + acc_cnt);
            res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = 1'b0;
        chk("wrap_sent", 64'(acc_cnt), 64'd12);
        drain("wrap_drain");

        // Flush with one queued and three in flight
        res_ready = 1'b0;
        req_valid = 1'b1; req_pt = {$urandom, $urandom}; req_tag = 8'hA0;
        tick();
        req_valid = 1'b0;
        repeat (16) tick();
        chk("fl_queued", 64'(res_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_pt = {$urandom, $urandom}; req_tag = TAGW'(8'hA1 + i);
            tick();
        end
        req_valid = 1'b0;
        chk("fl_inflight_pre", 64'(inflight), 64'd3);
        flush = 1'b1; req_valid = 1'b1;
        #1 chk("fl_ready_low", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("fl_res_valid", 64'(res_valid), 64'd0);
        chk("fl_inflight", 64'(inflight), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        res_ready = 1'b1; stray = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (res_valid) stray++;
        end
        chk("fl_no_stale", 64'(stray), 64'd0);
        tick();

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_pt = {$urandom, $urandom}; req_tag = TAGW'(8'hC0 + i);
            tick();
        end
        repeat (12) tick();
        @(posedge clk);
        #3;
        rst = 1'b1; req_valid = 1'b0;
        sb.delete();
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #4 rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_pt = {$urandom, $urandom}; req_tag = TAGW'(8'hD0 + i);
            tick();
        end
        drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/des_sched.md
# des_sched

Request scheduler and result buffer for the pipelined `des_enc` core. It accepts plaintext encrypt requests over a valid/ready handshake and issues at most one block per cycle into the core. It tracks each in-flight block with a tag through a shift register matched to the core latency, and collects ciphertexts into a small first-word-fall-through result FIFO. Credit-based backpressure ensures no result is ever dropped. It sits between the user/message-select logic (plaintext source) and the display/readout logic (ciphertext sink).

## Interface
Parameters:
- `LATENCY`, 16: cycles from `des_in` change to the matching `des_out`; must be ≥ 1.
- `DEPTH`, 4: result FIFO entries; also the credit limit. Power of two, ≥ 2.
- `TAGW`, 8: request tag width.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `flush`, in, 1: synchronous abort; discards in-flight blocks and FIFO contents.
- `req_valid`, in, 1: requester has a block.
- `req_ready`, out, 1: scheduler can accept a block this cycle.
- `req_pt`, in, 64: plaintext.
- `req_tag`, in, TAGW: opaque tag returned with the result.
- `des_in`, out, 64: registered plaintext to `des_enc.in`.
- `des_out`, in, 64: from `des_enc.out`.
- `res_valid`, out, 1: FIFO head is valid.
- `res_ready`, in, 1: consumer pops the head.
- `res_ct`, out, 64: head ciphertext.
- `res_tag`, out, TAGW: head tag.
- `busy`, out, 1: at least one block is in flight in the core.
- `inflight`, out, clog2(DEPTH)+1: blocks in the core pipeline.

## Operation
- Accept when `req_valid & req_ready`. On that edge: `des_in <= req_pt`, and the valid+tag shift register stage 0 is loaded with {1, `req_tag`}. On all other edges stage 0 is loaded with 0. `des_in` holds its value when no request is accepted.
- The shift register has `LATENCY` stages and shifts every cycle. When the last stage is valid, `{des_out, tag}` is written into the FIFO on that edge.
- Credit: `req_ready = !flush && (inflight + fifo_count) < DEPTH`. Every issued block is therefore guaranteed a FIFO slot, and the FIFO never overflows.
- `inflight` increments on accept and decrements on capture. Both in the same cycle leave it unchanged.
- FIFO pop on `res_valid & res_ready`. A push and a pop in the same cycle are both honoured. Pop when empty has no effect.
- `res_ct`/`res_tag` are driven from the head entry with no extra latency (FWFT). Contents are undefined when `res_valid` is 0.
- `flush`: on that edge, clear all shift-register valids, FIFO pointers/count and `inflight`. Requests are not accepted while `flush` is high, and captures in that cycle are discarded.
- `busy = (inflight != 0)`.
- Pointer wrap-around is modulo `DEPTH`. The count distinguishes full from empty.

## Timing
- Reset values: `req_ready`=1, `des_in`=0, `res_valid`=0, `res_ct`=0, `res_tag`=0, `busy`=0, `inflight`=0. All shift-register valids and FIFO state are cleared.
- Reset mid-operation clears everything immediately, without waiting for a clock. In-flight results are lost.
- Accept at edge E0 → `des_in` is valid from E0 → capture at edge E0+`LATENCY` → `res_valid` is high in the cycle after that edge. Minimum accept-to-`res_valid` is `LATENCY` cycles.
- Throughput is 1 block/cycle while credits remain. With `res_ready` held low, at most `DEPTH` blocks are accepted.
- `req_ready` depends only on registered state and `flush`. There is no combinational path from `req_valid` or `res_ready` to `req_ready`.
- A credit freed by a pop at edge E is usable from the cycle after E.
- Results leave in issue order. Tags are returned unmodified.

## Test plan
- Single request, LATENCY=16: `req_pt`=64'h0123456789ABCDEF, tag 8'h5A accepted at E0 → `res_valid` rises after E16, with `res_ct` equal to the `des_out` value at E16 and `res_tag`=8'h5A. `busy` is high for exactly 16 cycles.
- Back-to-back burst: 4 requests on consecutive cycles with `res_ready`=1 → 4 results on 4 consecutive cycles, in tag order 0,1,2,3.
- Backpressure: `res_ready`=0 and `req_valid`=1 continuously → exactly 4 accepts, after which `req_ready`=0. Assert `res_ready` for one cycle → `req_ready` returns next cycle and one more block is accepted. No result is lost.
- Simultaneous push/pop while the FIFO holds 2 entries → count stays 2 and order is preserved. Also wrap the pointers ≥ 3 times with 12 blocks.
- `flush` asserted with 3 blocks in flight and 1 queued → next cycle `res_valid`=0 and `inflight`=0, and no stale result ever appears afterwards.
- Async `rst` pulse mid-burst, not aligned to `clk` → outputs reach their reset values before the next edge, and normal operation resumes after release.
